// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types, default widths and round-robin pick for sram_arbiter
package sram_arb_pkg;
   typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_t;
   localparam int ADDR_W_DEF = 19;
   localparam int DATA_W_DEF = 1536;
   // Scans downward so the requester closest at/after ptr is the last one written.
   function automatic int unsigned rr_pick(input logic [7:0] req, input int unsigned ptr, input int unsigned n);
      logic [2:0] idx;
      rr_pick = ptr;
      for (int unsigned k = n; k > 0; k--) begin
         idx = 3'((ptr + k - 1) % n);
         if (req[idx]) rr_pick = 32'(idx);
      end
   endfunction
endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: client request/grant bundle plus the shared SRAM port
//   clnt_req/ren/wen/addr/wdata : from clients (addr/wdata packed, client i at [i*W +: W])
//   clnt_gnt/rvalid/rdata       : to clients
//   sram_ren/wen/addr/wdata     : to SRAM; sram_rdata from SRAM
//   conflict_err                : sticky owner ren+wen flag
//   modport slave = arbiter side, modport master = client/SRAM side
interface sram_arbiter_if import sram_arb_pkg::*; #(
   parameter int NUM_CLIENTS = 2,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic [NUM_CLIENTS-1:0] clnt_req, clnt_ren, clnt_wen, clnt_gnt, clnt_rvalid;
   logic [NUM_CLIENTS*ADDR_W-1:0] clnt_addr;
   logic [NUM_CLIENTS*DATA_W-1:0] clnt_wdata;
   logic [DATA_W-1:0] clnt_rdata, sram_wdata, sram_rdata;
   logic [ADDR_W-1:0] sram_addr;
   logic sram_ren, sram_wen, conflict_err;
   modport slave (
      input  clnt_req, clnt_ren, clnt_wen, clnt_addr, clnt_wdata, sram_rdata,
      output clnt_gnt, clnt_rvalid, clnt_rdata, sram_ren, sram_wen, sram_addr, sram_wdata, conflict_err
   );
   modport master (
      output clnt_req, clnt_ren, clnt_wen, clnt_addr, clnt_wdata, sram_rdata,
      input  clnt_gnt, clnt_rvalid, clnt_rdata, sram_ren, sram_wen, sram_addr, sram_wdata, conflict_err
   );
endinterface

// File: rtl/sram_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: READ_LATENCY-deep shift register of one-hot read tags driving clnt_rvalid
//   clk, n_rst (async, active-low) ; tag_in: issuing client one-hot ; tag_out: rvalid strobes
module rd_tag_pipe import sram_arb_pkg::*; #(
   parameter int NUM_CLIENTS = 2,
   parameter int READ_LATENCY = 1
) (
   input  logic clk,
   input  logic n_rst,
   input  logic [NUM_CLIENTS-1:0] tag_in,
   output logic [NUM_CLIENTS-1:0] tag_out
);
   logic [NUM_CLIENTS-1:0] stage [READ_LATENCY];
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         for (int i = 0; i < READ_LATENCY; i++) stage[i] <= '0;
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < READ_LATENCY; i++) stage[i] <= stage[i-1];
      end
   assign tag_out = stage[READ_LATENCY-1];
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin N-client arbiter for the shared frame-buffer SRAM port
//   clk, n_rst (async, active-low) ; bus: sram_arbiter_if.slave (client handshakes + SRAM port)
//   Optional burst limit via `define SRAM_ARB_BURST_LIMIT_EN (uses MAX_BURST)
module sram_arbiter import sram_arb_pkg::*; #(
   parameter int NUM_CLIENTS = 2,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int READ_LATENCY = 1,
   parameter int MAX_BURST = 64
) (
   input logic clk,
   input logic n_rst,
   sram_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_CLIENTS);
   state_t state;
   logic [IW-1:0] own, rr_ptr, winner;
   logic [NUM_CLIENTS-1:0] gnt, rd_tag, rvalid;
   logic [ADDR_W-1:0] sram_addr, own_addr;
   logic [DATA_W-1:0] sram_wdata, own_wdata;
   logic sram_ren, sram_wen, conflict_err, own_req, own_ren, own_wen, granted, revoke, rd_cmd;

   if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || READ_LATENCY < 1 || READ_LATENCY > 4 || MAX_BURST < 1) begin : g_bad_param
      $error("sram_arbiter: parameter out of range");
   end

   assign granted = state == OWN;
   assign winner = IW'(rr_pick(8'(bus.clnt_req), 32'(rr_ptr), NUM_CLIENTS));
   // A simultaneous ren+wen is resolved as a write.
   assign rd_cmd = granted && own_ren && !own_wen;

   always_comb begin
      own_req = 1'b0;
      own_ren = 1'b0;
      own_wen = 1'b0;
      own_addr = '0;
      own_wdata = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (own == IW'(i)) begin
            own_req = bus.clnt_req[i];
            own_ren = bus.clnt_ren[i];
            own_wen = bus.clnt_wen[i];
            own_addr = bus.clnt_addr[i*ADDR_W +: ADDR_W];
            own_wdata = bus.clnt_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef SRAM_ARB_BURST_LIMIT_EN
   localparam int BW = $clog2(MAX_BURST + 1);
   logic [BW-1:0] burst_cnt, burst_nxt;
   assign burst_nxt = burst_cnt == BW'(MAX_BURST) ? burst_cnt : burst_cnt + 1'b1;
   // gnt is the owner's one-hot while granted, so masking it leaves only competitors.
   assign revoke = granted && burst_nxt == BW'(MAX_BURST) && |(bus.clnt_req & ~gnt);
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) burst_cnt <= '0;
      else burst_cnt <= granted && own_req && !revoke ? burst_nxt : '0;
`else
   assign revoke = 1'b0;
`endif

   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         state <= IDLE;
         own <= '0;
         rr_ptr <= '0;
         gnt <= '0;
         rd_tag <= '0;
         sram_ren <= 1'b0;
         sram_wen <= 1'b0;
         sram_addr <= '0;
         sram_wdata <= '0;
         conflict_err <= 1'b0;
      end else begin
         sram_ren <= rd_cmd;
         sram_wen <= granted && own_wen;
         rd_tag <= rd_cmd ? gnt : '0;
         conflict_err <= conflict_err || (granted && own_ren && own_wen);
         if (granted && (own_ren || own_wen)) begin
            sram_addr <= own_addr;
            sram_wdata <= own_wdata;
         end
         case (state)
            IDLE:
               if (|bus.clnt_req) begin
                  gnt <= NUM_CLIENTS'(1) << winner;
                  own <= winner;
                  rr_ptr <= winner == IW'(NUM_CLIENTS - 1) ? '0 : winner + 1'b1;
                  state <= OWN;
               end
            OWN:
               if (!own_req || revoke) begin
                  gnt <= '0;
                  state <= RELEASE;
               end
            default: state <= IDLE;
         endcase
      end

   rd_tag_pipe #(.NUM_CLIENTS(NUM_CLIENTS), .READ_LATENCY(READ_LATENCY)) u_rd_tag_pipe (
      .clk(clk),
      .n_rst(n_rst),
      .tag_in(rd_tag),
      .tag_out(rvalid)
   );

   assign bus.clnt_gnt = gnt;
   assign bus.clnt_rvalid = rvalid;
   assign bus.clnt_rdata = bus.sram_rdata;
   assign bus.sram_ren = sram_ren;
   assign bus.sram_wen = sram_wen;
   assign bus.sram_addr = sram_addr;
   assign bus.sram_wdata = sram_wdata;
   assign bus.conflict_err = conflict_err;
endmodule
